// File: rtl/simd_add_arbiter.sv
// ---------------------------------------------------------------------------
// simd_add_arbiter
//
// Shares one combinational 64-bit SIMD nibble adder between NUM_REQ
// requesters. A combinational arbiter picks one valid requester per cycle.
// The accepted operands go into a registered issue stage (S1) that drives
// the adder. The adder result is captured into a registered response stage
// (S2) and returned tagged with the originating requester index.
//
// Optional build macro:
//   SIMD_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                           undefined -> round-robin starting at rr_ptr
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on a same-cycle transfer elsewhere except
// through the pipeline-advance term below. A requester holds valid and
// payload stable until it sees its ready bit high.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid    per-requester request valid           [NUM_REQ]
//   req_ready    per-requester accept, one-hot or zero [NUM_REQ]
//   req_a/req_b  packed operands, requester i at [64i+63:64i]
//   req_conf     packed adder conf, requester i at [4i+3:4i]
//   add_a/add_b  registered operands to the shared adder
//   add_conf     registered conf to the shared adder (bit 3 en, bit 2 sub)
//   add_cout     adder result, combinational in add_a/add_b/add_conf
//   rsp_valid    response valid
//   rsp_ready    response consumer ready
//   rsp_data     captured adder result
//   rsp_id       index of the originating requester
//   op_count     saturating count of completed responses
// ---------------------------------------------------------------------------
module simd_add_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [64*NUM_REQ-1:0] req_a,
    input  logic [64*NUM_REQ-1:0] req_b,
    input  logic [4*NUM_REQ-1:0]  req_conf,
    output logic [63:0]           add_a,
    output logic [63:0]           add_b,
    output logic [3:0]            add_conf,
    input  logic [63:0]           add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [63:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic [CNT_W-1:0]      op_count
);

    logic            s1_v;
    logic [ID_W-1:0] s1_id;
    logic [ID_W-1:0] rr_ptr;
    logic            adv;
    logic            accept_ok;
    logic            accept;
    logic            win_found;
    logic [ID_W-1:0] win;
    logic [ID_W:0]   cand_sum;
    logic [ID_W-1:0] cand;

    // S2 can take a new entry when it is empty or being drained this cycle;
    // S1 can take a new entry when it is empty or moving into S2.
    assign adv       = !rsp_valid || rsp_ready;
    assign accept_ok = !s1_v || adv;
    assign accept    = win_found && accept_ok;

    // Search starting at rr_ptr, wrapping modulo NUM_REQ. With rr_ptr held
    // at zero this degenerates to lowest-index-wins fixed priority.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            cand     = (cand_sum >= (ID_W+1)'(NUM_REQ))
                       ? ID_W'(cand_sum - (ID_W+1)'(NUM_REQ))
                       : cand_sum[ID_W-1:0];
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

`ifdef SIMD_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
        end
    end
`endif

    // Issue stage. Operands clear when the stage empties without a refill so
    // the idle adder sees conf[3]=0 and passes zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_id    <= '0;
            add_a    <= '0;
            add_b    <= '0;
            add_conf <= '0;
        end else if (accept) begin
            s1_v     <= 1'b1;
            s1_id    <= win;
            add_a    <= req_a[{win, 6'b0} +: 64];
            add_b    <= req_b[{win, 6'b0} +: 64];
            add_conf <= req_conf[{win, 2'b0} +: 4];
        end else if (s1_v && adv) begin
            s1_v     <= 1'b0;
            add_a    <= '0;
            add_b    <= '0;
            add_conf <= '0;
        end
    end

    // Response stage; rsp_valid doubles as the S2 occupancy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (adv) begin
            if (s1_v) begin
                rsp_valid <= 1'b1;
                rsp_data  <= add_cout;
                rsp_id    <= s1_id;
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready && (op_count != '1)) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_simd_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_simd_add_arbiter
//
// Bench for simd_add_arbiter (NUM_REQ=2, CNT_W=4 so saturation is reachable).
// Provides the shared nibble adder, drives requesters that hold their
// payload until accepted, and compares the DUT against a transaction-level
// model: an in-order queue of expected results with a capacity of two, a
// round-robin (or fixed-priority) winner rule, and a saturating counter.
// ---------------------------------------------------------------------------
module tb_simd_add_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [64*NUM_REQ-1:0] req_a;
    logic [64*NUM_REQ-1:0] req_b;
    logic [4*NUM_REQ-1:0]  req_conf;
    logic [63:0]           add_a;
    logic [63:0]           add_b;
    logic [3:0]            add_conf;
    logic [63:0]           add_cout;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [63:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic [CNT_W-1:0]      op_count;

    simd_add_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_conf  (req_conf),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_conf  (add_conf),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    // Shared adder: 16 independent 4-bit lanes, conf[3] enable, conf[2] sub.
    function automatic logic [63:0] nib_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [3:0]  conf);
        logic [63:0] r;
        r = a;
        if (conf[3]) begin
            for (int l = 0; l < 16; l++) begin
                r[4*l +: 4] = conf[2] ? (a[4*l +: 4] - b[4*l +: 4])
                                      : (a[4*l +: 4] + b[4*l +: 4]);
            end
        end
        return r;
    endfunction

    assign add_cout = nib_add(add_a, add_b, add_conf);

    // ---------------- scoreboard / model state ----------------
    logic [ID_W+63:0] exp_q[$];   // {id, result} in completion order
    int               age_q[$];   // edges each queued op has spent inside
    int               rr_ptr_m;
    int               cnt_m;
    int               got_ids[$];
    int               acc_cnt;
    int               errors;
    int               checks;

    logic        pend [NUM_REQ];
    logic [63:0] pa   [NUM_REQ];
    logic [63:0] pb   [NUM_REQ];
    logic [3:0]  pc   [NUM_REQ];

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int r, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] c);
        pend[r] = 1'b1;
        pa[r]   = a;
        pb[r]   = b;
        pc[r]   = c;
    endtask

    task automatic refill(input int r);
        if (!pend[r]) begin
            set_req(r, {$urandom, $urandom}, {$urandom, $urandom},
                    4'($urandom_range(0, 15)));
        end
    endtask

    task automatic drive_reqs();
        for (int r = 0; r < NUM_REQ; r++) begin
            req_valid[r]         = pend[r];
            req_a[64*r +: 64]    = pa[r];
            req_b[64*r +: 64]    = pb[r];
            req_conf[4*r +: 4]   = pc[r];
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        age_q.delete();
        rr_ptr_m = 0;
        cnt_m    = 0;
        for (int r = 0; r < NUM_REQ; r++) pend[r] = 1'b0;
    endtask

    function automatic int pick_winner();
        for (int i = 0; i < NUM_REQ; i++) begin
            int r;
`ifdef SIMD_ARB_FIXED_PRIO_EN
            r = i;
`else
            r = (rr_ptr_m + i) % NUM_REQ;
`endif
            if (pend[r]) return r;
        end
        return -1;
    endfunction

    // One clock cycle. Entered and left 1 time unit after a rising edge.
    task automatic step();
        int               win;
        logic             ok;
        logic             vis;
        logic             s1_busy;
        logic [ID_W+63:0] head;
        logic [NUM_REQ-1:0] exp_ready;
        drive_reqs();
        #1;
        win       = pick_winner();
        ok        = (exp_q.size() < 2) || rsp_ready;
        exp_ready = '0;
        if (win >= 0 && ok) exp_ready[win] = 1'b1;
        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
        vis = (exp_q.size() > 0) && (age_q[0] >= 1);
        check_eq("rsp_valid", 64'(rsp_valid), 64'(vis));
        if (vis) begin
            head = exp_q[0];
            check_eq("rsp_data", rsp_data, head[63:0]);
            check_eq("rsp_id", 64'(rsp_id), 64'(head[64 +: ID_W]));
        end
        check_eq("op_count", 64'(op_count), 64'(cnt_m));
        s1_busy = (exp_q.size() == 2) || (exp_q.size() == 1 && age_q[0] == 0);
        if (!s1_busy) begin
            check_eq("idle_add_a", add_a, 64'h0);
            check_eq("idle_add_conf", 64'(add_conf), 64'h0);
        end
        if (rsp_valid === 1'b1 && rsp_ready) got_ids.push_back(int'(rsp_id));
        acc_cnt += $countones(req_valid & req_ready);
        @(posedge clk);
        if (vis && rsp_ready) begin
            void'(exp_q.pop_front());
            void'(age_q.pop_front());
            if (cnt_m < CNT_MAX) cnt_m++;
        end
        foreach (age_q[k]) age_q[k]++;
        if (win >= 0 && ok) begin
            exp_q.push_back({ID_W'(win), nib_add(pa[win], pb[win], pc[win])});
            age_q.push_back(0);
            pend[win] = 1'b0;
            rr_ptr_m  = (win + 1) % NUM_REQ;
        end
        #1;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (exp_q.size() == 0 && !pend[0] && !pend[1]) break;
            step();
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int exp_id;
        errors    = 0;
        checks    = 0;
        acc_cnt   = 0;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_conf  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            pa[r] = '0;
            pb[r] = '0;
            pc[r] = '0;
        end
        model_reset();
        drive_reqs();

        // Reset state
        rst_n = 1'b0;
        #3;
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check_eq("rst_add_a", add_a, 64'h0);
        check_eq("rst_op_count", 64'(op_count), 64'h0);
        check_eq("rst_req_ready", 64'(req_ready), 64'h0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single add on requester 0
        rsp_ready = 1'b1;
        set_req(0, 64'h0123456789ABCDEF, 64'h1111111111111111, 4'b1000);
        step();
        step();
        check_eq("single_valid", 64'(rsp_valid), 64'h1);
        check_eq("single_data", rsp_data, 64'h123456789ABCDEF0);
        check_eq("single_id", 64'(rsp_id), 64'h0);
        step();
        check_eq("single_count", 64'(op_count), 64'h1);

        // Subtract on requester 1
        set_req(1, 64'h0, 64'h1111111111111111, 4'b1100);
        step();
        step();
        check_eq("sub_data", rsp_data, 64'hFFFFFFFFFFFFFFFF);
        check_eq("sub_id", 64'(rsp_id), 64'h1);
        step();

        // Passthrough (adder disabled) on requester 1
        set_req(1, 64'hDEAD, 64'h5555AAAA5555AAAA, 4'b0000);
        step();
        step();
        check_eq("pass_data", rsp_data, 64'hDEAD);
        step();
        drain();

        // Contention: both requesters valid continuously
        got_ids.delete();
        for (int n = 0; n < 10; n++) begin
            refill(0);
            refill(1);
            step();
        end
        drain();
        check_eq("cont_count", 64'(got_ids.size() >= 6), 64'h1);
        for (int k = 0; k < 6 && k < got_ids.size(); k++) begin
`ifdef SIMD_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = k % 2;
`endif
            check_eq($sformatf("cont_id%0d", k), 64'(got_ids[k]), 64'(exp_id));
        end

        // Backpressure: consumer stalled, requesters keep pushing
        rsp_ready = 1'b0;
        acc_cnt   = 0;
        for (int n = 0; n < 5; n++) begin
            refill(0);
            refill(1);
            step();
        end
        check_eq("bp_accepts", 64'(acc_cnt), 64'h2);
        drive_reqs();
        #1;
        check_eq("bp_ready", 64'(req_ready), 64'h0);
        drain();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if ($urandom_range(0, 2) != 0) refill(r);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Reset with both stages full
        rsp_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            refill(0);
            refill(1);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check_eq("mid_rst_add_a", add_a, 64'h0);
        check_eq("mid_rst_op_count", 64'(op_count), 64'h0);
        model_reset();
        drive_reqs();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int n = 0; n < 3; n++) step();

        // Saturation: 19 completions on a 4-bit counter
        got_ids.delete();
        for (int n = 0; n < 80 && got_ids.size() < 19; n++) begin
            refill(0);
            step();
        end
        check_eq("sat_done", 64'(got_ids.size()), 64'd19);
        check_eq("sat_count", 64'(op_count), 64'hF);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_add_arbiter.md
Name: simd_add_arbiter

Overview:
- Shares one combinational 64-bit SIMD nibble adder (16 × 4-bit lanes; conf[3] enable, conf[2] subtract) between NUM_REQ requesters.
- Arbitrates per-cycle with valid/ready handshakes and drives the adder operands from a registered issue stage.
- Captures the adder result into a registered response stage and returns it tagged with the requester index.
- Sits between the digital-interface command sources and the single shared adder instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, response tag width; must equal clog2(NUM_REQ), minimum 1.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  64*NUM_REQ  operand A; requester i occupies bits [64i+63:64i].
- req_b  in  64*NUM_REQ  operand B, packed the same way as req_a.
- req_conf  in  4*NUM_REQ  adder conf, [4i+3:4i]; bits [1:0] reserved, passed through unchanged.
- add_a  out  64  registered operand A to the shared adder.
- add_b  out  64  registered operand B to the shared adder.
- add_conf  out  4  registered conf to the shared adder.
- add_cout  in  64  adder result; combinational function of add_a, add_b, add_conf.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  64  captured adder result.
- rsp_id  out  ID_W  index of the originating requester.
- op_count  out  CNT_W  saturating count of completed responses (rsp_valid & rsp_ready).

Behaviour:
- Reset (async, rst_n=0): s1_v=0, s2_v=0, add_a/add_b/add_conf=0, rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, op_count=0. Any in-flight operation is discarded.
- Two-stage pipeline:
  - S1 (issue): registers add_a, add_b, add_conf, s1_id, s1_v.
  - S2 (response): registers rsp_data, rsp_id, rsp_valid.
- adv = !s2_v | rsp_ready. accept_ok = !s1_v | adv.
- Grant is combinational.
  - Round-robin: search starts at rr_ptr and wraps modulo NUM_REQ; the first requester with req_valid asserted wins.
  - req_ready[win] = accept_ok. All other req_ready bits are 0.
  - With no valid requesters, req_ready is all zeros.
- On accept (req_valid[win] & req_ready[win]):
  - S1 loads req_a/b/conf slices and s1_id=win.
  - s1_v=1.
  - rr_ptr=(win+1) mod NUM_REQ.
- rr_ptr is unchanged when nothing is accepted.
- On adv & s1_v: S2 loads rsp_data=add_cout, rsp_id=s1_id, rsp_valid=1.
- On adv & !s1_v: rsp_valid=0.
- When S1 empties without a refill, add_a/b/conf clear to 0. conf[3]=0 then makes the adder pass add_a (0).
- Latency: accept at edge T → rsp_valid high after edge T+1. Throughput is 1 op/cycle with rsp_ready held high.
- Backpressure: while rsp_valid=1 & rsp_ready=0, S2 holds. S1 holds if full. req_ready=0 if S1 is full.
- Simultaneous S2 drain, S1→S2 move and new accept in one cycle is legal and must not drop or duplicate an operation.
- Requester rules:
  - Must hold req_valid and payload stable until accepted.
  - The block never drops an asserted request.
  - Starvation bound (round-robin): NUM_REQ grants.
- op_count increments on rsp_valid & rsp_ready and saturates at all-ones.
- Adder arithmetic (lane-wise mod 16, no inter-lane carry) is outside this block; the block forwards conf bits untouched.

Optional Feature:
- SIMD_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest index with req_valid wins. rr_ptr is not implemented and stays 0.
  - Undefined: round-robin as specified above.
- Handshake, latency and pipeline behaviour are identical in both builds.

Test Plan:
- Single op: req0 A=64'h0123456789ABCDEF, B=64'h1111111111111111, conf=4'b1000, rsp_ready=1 → one cycle later rsp_data=64'h123456789ABCDEF0, rsp_id=0, op_count=1.
- Subtract: req1 A=0, B=64'h1111111111111111, conf=4'b1100 → rsp_data=64'hFFFFFFFFFFFFFFFF, rsp_id=1. Passthrough with conf=4'b0000 and A=64'hDEAD → rsp_data=64'hDEAD.
- Contention: both requesters valid continuously for 6 ops, rsp_ready=1 → rsp_id sequence 0,1,0,1,0,1. With SIMD_ARB_FIXED_PRIO_EN defined → 0,0,0 until req0 drops.
- Backpressure: hold rsp_ready=0 for 5 cycles with back-to-back requests → exactly 2 accepted (S1, S2 full), req_ready=0 afterwards. On release, responses drain in order with no loss or duplication.
- Reset mid-operation: assert rst_n=0 while s1_v=s2_v=1 → rsp_valid=0, add_a=0 and op_count=0 immediately (async). No stale response appears after reset release.
- Saturation: force 2^CNT_W+3 completions (CNT_W=4 build: 19) → op_count holds at 4'hF.
